ssp_uart_reg_arb: RTL and testbench
===================================

Name:
ssp_uart_reg_arb

Overview:
- Two-requester arbiter and access sequencer for the ssp_uart register file (UCR, USR, TDR, RDR, SPR).
- Converts valid/ready register requests into fixed-timing register cycles: address setup, enable pulse, end-of-cycle strobe.
- Returns one response per request.
- Sits between on-chip masters (e.g. interrupt service engine on port 0, TX streamer on port 1) and the UART register bus.
- Round-robin fairness, plus a lock for read-modify-write sequences.

Parameters:
- ACC_CYCLES, 2, number of cycles Bus_En is held high per access (legal 1..15).
- AW, 3, register address width.
- DW, 12, register data width.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ReqN_Valid  in  1  (N=0,1) request present; held with fields stable until ReqN_Ready.
- ReqN_Ready  out  1  request accepted this cycle.
- ReqN_RA  in  AW  register address (000 UCR, 001 USR, 010 TDR, 011 RDR, 100 SPR).
- ReqN_WnR  in  1  1 = write, 0 = read.
- ReqN_DI  in  DW  write data.
- ReqN_Lock  in  1  keep grant for this requester's next request.
- RspN_Valid  out  1  one-cycle response strobe.
- RspN_DO  out  DW  read data; 0 for writes.
- Bus_RA  out  AW  register address to UART core.
- Bus_WnR  out  1  access direction.
- Bus_DI  out  DW  write data to core.
- Bus_En  out  1  access enable.
- Bus_EOC  out  1  end-of-cycle strobe.
- Bus_DO  in  DW  read data from core, valid while Bus_EOC=1.

Behaviour:
- Reset:
  - State IDLE; all outputs 0; RR pointer = 0 (port 0 wins the first tie); lock cleared.
  - Reset asserted mid-access aborts it: no response issued; Bus_En and Bus_EOC low at the next edge.
- States: IDLE -> SETUP -> ACCESS -> EOC -> RESP -> IDLE.
- IDLE:
  - Bus outputs 0.
  - ReqN_Ready is combinational: asserted only for the granted port, and only when its Valid=1.
  - On Valid&Ready, latch RA/WnR/DI/Lock and the port id, then go to SETUP.
- Grant rule:
  - If lock is held, only the lock owner can be granted.
  - Otherwise, if exactly one port is valid, grant it.
  - If both are valid, grant the port not served last (RR pointer). The pointer updates on every acceptance.
- SETUP (1 cycle): Bus_RA/WnR/DI driven from the latch; Bus_En=0.
- ACCESS (ACC_CYCLES cycles, internal 4-bit counter): Bus_En=1, bus fields held.
- EOC (1 cycle):
  - Bus_EOC=1, Bus_En=0, bus fields held.
  - On reads, Bus_DO is captured at the end of this cycle.
- RESP (1 cycle):
  - RspN_Valid=1 for the owner only.
  - RspN_DO = captured data for reads, 0 for writes.
  - Bus outputs 0.
  - RspN_DO holds its value until the next response on that port.
- Latency: acceptance in cycle T -> Bus_En high T+2..T+1+ACC_CYCLES, Bus_EOC at T+ACC_CYCLES+2, RspN_Valid at T+ACC_CYCLES+3. The next acceptance is possible at T+ACC_CYCLES+4.
- Lock:
  - Set when a request is accepted with Lock=1; cleared when the owner's request is accepted with Lock=0.
  - While locked, the other port's Ready stays 0 regardless of the RR pointer.
- Valid dropped before Ready: no access occurs and no state change.
- Only one access is outstanding at a time; no request buffering beyond the latch.

Test Plan:
- Reset check: Rst=1 for 10 Clk cycles with both Valid=1 -> all outputs 0, Ready0/Ready1=0 throughout. After release, Req0 is accepted first.
- Port 0 write, RA=010, DI=12'h0A5, ACC_CYCLES=2, accepted at T -> Bus_RA=010, Bus_WnR=1, Bus_DI=12'h0A5 from T+1. Bus_En=1 at T+2..T+3, Bus_EOC=1 at T+4, Rsp0_Valid=1 at T+5 with Rsp0_DO=0.
- Port 1 read, RA=001, Bus_DO=12'h3C0 during EOC -> Rsp1_Valid one cycle with Rsp1_DO=12'h3C0. Bus_WnR=0 throughout.
- Both ports continuously valid for 4 requests -> grant order 0,1,0,1. Each request gets exactly one RspN_Valid.
- Port 1 read USR with Lock=1 while Req0_Valid=1, then port 1 write UCR with Lock=0 -> both port-1 accesses complete before Ready0 rises. Port 0 is accepted immediately after.
- Rst pulsed during ACCESS -> Bus_En=0 next cycle, no RspN_Valid. The subsequent tie is granted to port 0.

Source files
------------

// File: rtl/ssp_uart_reg_arb.sv
// Two-port round-robin arbiter that sequences ssp_uart register accesses
// as SETUP -> ACCESS (ACC_CYCLES of Bus_En) -> EOC -> RESP, with a read-modify-write lock.
//
// state     | meaning
// ST_IDLE   | bus quiet, grant evaluated, request latched on acceptance
// ST_SETUP  | address/direction/data driven, enable low
// ST_ACCESS | enable high for ACC_CYCLES cycles
// ST_EOC    | end-of-cycle strobe, read data captured
// ST_RESP   | one-cycle response to the owning port
module ssp_uart_reg_arb #(
    parameter int ACC_CYCLES = 2,
    parameter int AW         = 3,
    parameter int DW         = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic [AW-1:0] i_req0_ra,
    input  logic          i_req0_wnr,
    input  logic [DW-1:0] i_req0_di,
    input  logic          i_req0_lock,
    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    input  logic [AW-1:0] i_req1_ra,
    input  logic          i_req1_wnr,
    input  logic [DW-1:0] i_req1_di,
    input  logic          i_req1_lock,
    output logic          o_rsp0_valid,
    output logic [DW-1:0] o_rsp0_do,
    output logic          o_rsp1_valid,
    output logic [DW-1:0] o_rsp1_do,
    output logic [AW-1:0] o_bus_ra,
    output logic          o_bus_wnr,
    output logic [DW-1:0] o_bus_di,
    output logic          o_bus_en,
    output logic          o_bus_eoc,
    input  logic [DW-1:0] i_bus_do
);

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_EOC, ST_RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

    state_t        r_state, w_next;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_ra;
    logic          r_wnr;
    logic [DW-1:0] r_di;
    logic          r_owner;
    logic          r_rr;
    logic          r_lock;
    logic          r_lock_owner;
    logic [DW-1:0] r_rsp0_do;
    logic [DW-1:0] r_rsp1_do;
    logic          w_grant;
    logic          w_grant_ok;
    logic          w_accept;

    // A held lock pins the grant to its owner regardless of the RR pointer.
    always_comb begin
        w_grant    = 1'b0;
        w_grant_ok = 1'b0;
        if (r_lock) begin
            w_grant    = r_lock_owner;
            w_grant_ok = r_lock_owner ? i_req1_valid : i_req0_valid;
        end else if (i_req0_valid && i_req1_valid) begin
            w_grant    = r_rr;
            w_grant_ok = 1'b1;
        end else if (i_req0_valid) begin
            w_grant_ok = 1'b1;
        end else if (i_req1_valid) begin
            w_grant    = 1'b1;
            w_grant_ok = 1'b1;
        end
    end

    assign w_accept     = (r_state == ST_IDLE) && w_grant_ok && !i_rst;
    assign o_req0_ready = w_accept && !w_grant;
    assign o_req1_ready = w_accept && w_grant;
    assign o_rsp0_do    = r_rsp0_do;
    assign o_rsp1_do    = r_rsp1_do;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_bus_ra     = '0;
        o_bus_wnr    = 1'b0;
        o_bus_di     = '0;
        o_bus_en     = 1'b0;
        o_bus_eoc    = 1'b0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_SETUP;
            end
            ST_SETUP: begin
                o_bus_ra  = r_ra;
                o_bus_wnr = r_wnr;
                o_bus_di  = r_di;
                w_next    = ST_ACCESS;
            end
            ST_ACCESS: begin
                o_bus_ra  = r_ra;
                o_bus_wnr = r_wnr;
                o_bus_di  = r_di;
                o_bus_en  = 1'b1;
                if (r_cnt == 4'd0) w_next = ST_EOC;
            end
            ST_EOC: begin
                o_bus_ra  = r_ra;
                o_bus_wnr = r_wnr;
                o_bus_di  = r_di;
                o_bus_eoc = 1'b1;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                o_rsp0_valid = !r_owner;
                o_rsp1_valid = r_owner;
                w_next       = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_ra         <= '0;
            r_wnr        <= 1'b0;
            r_di         <= '0;
            r_owner      <= 1'b0;
            r_rr         <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_owner <= 1'b0;
            r_rsp0_do    <= '0;
            r_rsp1_do    <= '0;
        end else begin
            if (w_accept) begin
                r_ra         <= w_grant ? i_req1_ra  : i_req0_ra;
                r_wnr        <= w_grant ? i_req1_wnr : i_req0_wnr;
                r_di         <= w_grant ? i_req1_di  : i_req0_di;
                r_lock       <= w_grant ? i_req1_lock : i_req0_lock;
                r_lock_owner <= w_grant;
                r_owner      <= w_grant;
                r_rr         <= !w_grant;
            end
            if (r_state == ST_SETUP)
                r_cnt <= CNT_LOAD;
            else if (r_state == ST_ACCESS && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            // Response data goes straight into the per-port holding register.
            if (r_state == ST_EOC) begin
                if (r_owner) r_rsp1_do <= r_wnr ? '0 : i_bus_do;
                else         r_rsp0_do <= r_wnr ? '0 : i_bus_do;
            end
        end
    end

endmodule

// File: tb/tb_ssp_uart_reg_arb.sv
// Directed bench for ssp_uart_reg_arb: reset, single accesses, round-robin,
// lock sequence and reset abort, each checked cycle by cycle against fixed timing.
module tb_ssp_uart_reg_arb;

    localparam int ACC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, rdy0, rdy1, wnr0, wnr1, lk0, lk1;
    logic [2:0]  ra0, ra1, bus_ra;
    logic [11:0] di0, di1, bus_di, bus_do, do0, do1, core_data;
    logic        rspv0, rspv1, bus_wnr, bus_en, bus_eoc;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int rsp0_cnt = 0;
    int rsp1_cnt = 0;

    always #5 clk = ~clk;

    assign bus_do = bus_eoc ? core_data : 12'hBAD;

    ssp_uart_reg_arb #(.ACC_CYCLES(ACC), .AW(3), .DW(12)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_ra(ra0), .i_req0_wnr(wnr0),
        .i_req0_di(di0), .i_req0_lock(lk0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_ra(ra1), .i_req1_wnr(wnr1),
        .i_req1_di(di1), .i_req1_lock(lk1),
        .o_rsp0_valid(rspv0), .o_rsp0_do(do0), .o_rsp1_valid(rspv1), .o_rsp1_do(do1),
        .o_bus_ra(bus_ra), .o_bus_wnr(bus_wnr), .o_bus_di(bus_di),
        .o_bus_en(bus_en), .o_bus_eoc(bus_eoc), .i_bus_do(bus_do)
    );

    always @(negedge clk) begin
        if (rspv0) rsp0_cnt++;
        if (rspv1) rsp1_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Starts in an IDLE cycle where `port` must be granted; ends in the next IDLE cycle.
    task automatic run_txn(input int port, input logic [2:0] ra, input logic wnr,
                           input logic [11:0] di, input logic [11:0] exp_do,
                           input logic drop0, input logic drop1);
        #1;
        check("grant_rdy0", rdy0, port == 0);
        check("grant_rdy1", rdy1, port == 1);
        step();
        if (drop0) v0 = 1'b0;
        if (drop1) v1 = 1'b0;
        #1;
        check("setup_ra", bus_ra, ra);
        check("setup_wnr", bus_wnr, wnr);
        check("setup_di", bus_di, di);
        check("setup_en", bus_en, 0);
        check("busy_rdy", {rdy0, rdy1}, 0);
        for (int i = 0; i < ACC; i++) begin
            step();
            check("acc_en", bus_en, 1);
            check("acc_eoc", bus_eoc, 0);
            check("acc_fields", {bus_ra, bus_wnr, bus_di}, {ra, wnr, di});
        end
        step();
        check("eoc_strobe", {bus_eoc, bus_en}, 2'b10);
        check("eoc_ra", bus_ra, ra);
        step();
        check("rsp_v0", rspv0, port == 0);
        check("rsp_v1", rspv1, port == 1);
        check("rsp_do", (port == 0) ? do0 : do1, exp_do);
        check("rsp_bus", {bus_en, bus_eoc, bus_ra, bus_di}, 0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        v0 = 1'b1; ra0 = 3'b010; wnr0 = 1'b1; di0 = 12'h0A5; lk0 = 1'b0;
        v1 = 1'b1; ra1 = 3'b001; wnr1 = 1'b0; di1 = 12'h000; lk1 = 1'b0;
        core_data = 12'h3C0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("reset_outs", {rdy0, rdy1, bus_en, bus_eoc, rspv0, rspv1, bus_wnr,
                                 |bus_ra, |bus_di, |do0, |do1}, 0);
        end
        rst = 1'b0;

        // Port 0 write after reset, then port 1 read waiting behind it
        run_txn(0, 3'b010, 1'b1, 12'h0A5, 12'h000, 1'b1, 1'b0);
        run_txn(1, 3'b001, 1'b0, 12'h000, 12'h3C0, 1'b0, 1'b1);

        // Both held valid: round-robin 0,1,0,1
        v0 = 1'b1; ra0 = 3'b000; wnr0 = 1'b1; di0 = 12'h111;
        v1 = 1'b1; ra1 = 3'b011; wnr1 = 1'b0;
        core_data = 12'h2E7;
        run_txn(0, 3'b000, 1'b1, 12'h111, 12'h000, 1'b0, 1'b0);
        run_txn(1, 3'b011, 1'b0, 12'h000, 12'h2E7, 1'b0, 1'b0);
        run_txn(0, 3'b000, 1'b1, 12'h111, 12'h000, 1'b0, 1'b0);
        run_txn(1, 3'b011, 1'b0, 12'h000, 12'h2E7, 1'b1, 1'b1);
        check("rr_rsp0_cnt", rsp0_cnt, 3);
        check("rr_rsp1_cnt", rsp1_cnt, 3);

        // Locked read-modify-write on port 1 while port 0 waits
        v1 = 1'b1; ra1 = 3'b001; wnr1 = 1'b0; lk1 = 1'b1;
        core_data = 12'h5A1;
        run_txn(1, 3'b001, 1'b0, 12'h000, 12'h5A1, 1'b0, 1'b0);
        v0 = 1'b1; ra0 = 3'b100; wnr0 = 1'b1; di0 = 12'h123;
        ra1 = 3'b000; wnr1 = 1'b1; di1 = 12'h5A3; lk1 = 1'b0;
        run_txn(1, 3'b000, 1'b1, 12'h5A3, 12'h000, 1'b0, 1'b1);
        run_txn(0, 3'b100, 1'b1, 12'h123, 12'h000, 1'b1, 1'b0);

        // Reset during ACCESS aborts the access; pointer returns to port 0
        v0 = 1'b1; ra0 = 3'b000; wnr0 = 1'b1; di0 = 12'h777;
        #1;
        check("abort_rdy0", rdy0, 1);
        step();
        step();
        check("abort_pre_en", bus_en, 1);
        rst = 1'b1;
        step();
        check("abort_en_eoc", {bus_en, bus_eoc, rspv0, rspv1}, 0);
        rst = 1'b0;
        v1 = 1'b1; ra1 = 3'b011; wnr1 = 1'b0;
        check("abort_rsp0_cnt", rsp0_cnt, 4);
        check("abort_rsp1_cnt", rsp1_cnt, 5);
        run_txn(0, 3'b000, 1'b1, 12'h777, 12'h000, 1'b1, 1'b1);
        check("final_rsp0_cnt", rsp0_cnt, 5);
        check("final_rsp1_cnt", rsp1_cnt, 5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
